shift_unit_arbiter: RTL and testbench

- Shares one instance of the team's combinational barrel_shifter (ports out, in, shiftamt, left; SLL when left=1, SRA when left=0) between two requesters.
- Round-robin arbitration with valid/ready handshakes.
- Sequences multi-pass operations: SRL and, optionally, ROL are built from SLL/SRA passes.
- Holds one response until the consumer accepts it. Sits beside the ALU as the shared shift resource.

---
 rtl/shift_unit_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_shift_unit_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter.sv
// Two-requester round-robin front end for one shared barrel shifter, with SRL/ROL built from SLL/SRA passes.
// Define SHIFT_ARB_ROTATE_EN to implement op 11 as ROL (adds pass state P3); otherwise op 11 is reported illegal.

module barrel_shifter (
  output logic [31:0] out,
  input  logic [31:0] in,
  input  logic [4:0]  shiftamt,
  input  logic        left
);
  logic signed [31:0] sra_val;

  // Kept in its own signed net so the arithmetic shift is not demoted to logical in the mux.
  assign sra_val = $signed(in) >>> shiftamt;
  assign out     = left ? (in << shiftamt) : sra_val;
endmodule

module shift_unit_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter bit INIT_PTR   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  input  logic [1:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        resp_err,
  output logic        busy
);
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
`ifdef SHIFT_ARB_ROTATE_EN
    P3   = 3'd3,
`endif
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q;
  logic [31:0] data_q, r1_q;
  logic [4:0]  amt_q, amt_comp;
  logic [1:0]  op_q;
  logic        idle, win1, accept;
  logic        zero_amt, is_srl, is_illegal, multi;
  logic [31:0] sh_in, sh_out;
  logic [4:0]  sh_amt;
  logic        sh_left;
`ifdef SHIFT_ARB_ROTATE_EN
  logic [31:0] r2_q;
  logic        is_rol;
`endif

  // Grants are gated by reset so both readies read 0 while reset is held.
  assign idle       = (state_q == IDLE) && !reset;
  assign win1       = !FIXED_PRIO && ptr_q;
  assign req0_ready = idle && req0_valid && (!req1_valid || !win1);
  assign req1_ready = idle && req1_valid && (!req0_valid || win1);
  assign accept     = req0_ready || req1_ready;
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  assign zero_amt = (amt_q == 5'd0);
  assign amt_comp = 5'd0 - amt_q;
  assign is_srl   = (op_q == OP_SRL) && !zero_amt;
`ifdef SHIFT_ARB_ROTATE_EN
  assign is_rol     = (op_q == OP_ROL) && !zero_amt;
  assign is_illegal = 1'b0;
  assign multi      = is_srl || is_rol;
`else
  assign is_illegal = (op_q == OP_ROL);
  assign multi      = is_srl;
`endif

  barrel_shifter u_shifter (
    .out      (sh_out),
    .in       (sh_in),
    .shiftamt (sh_amt),
    .left     (sh_left)
  );

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sh_in   = data_q;
    sh_amt  = amt_q;
    sh_left = 1'b1;
    case (state_q)
      P1: sh_left = !((op_q == OP_SRA) || is_srl);
      P2: begin
        sh_in  = 32'hFFFF_FFFF;
        sh_amt = amt_comp;
`ifdef SHIFT_ARB_ROTATE_EN
        if (is_rol) begin
          sh_in   = data_q;
          sh_left = 1'b0;
        end
`endif
      end
`ifdef SHIFT_ARB_ROTATE_EN
      P3: sh_in = 32'hFFFF_FFFF;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = P1;
      P1:   state_d = multi ? P2 : DONE;
`ifdef SHIFT_ARB_ROTATE_EN
      P2:   state_d = is_rol ? P3 : DONE;
      P3:   state_d = DONE;
`else
      P2:   state_d = DONE;
`endif
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= INIT_PTR;
      data_q    <= '0;
      amt_q     <= '0;
      op_q      <= '0;
      r1_q      <= '0;
`ifdef SHIFT_ARB_ROTATE_EN
      r2_q      <= '0;
`endif
      resp_data <= '0;
      resp_id   <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        data_q  <= req1_ready ? req1_data : req0_data;
        amt_q   <= req1_ready ? req1_amt  : req0_amt;
        op_q    <= req1_ready ? req1_op   : req0_op;
        resp_id <= req1_ready;
        if (!FIXED_PRIO) ptr_q <= !req1_ready;
      end
      // Multi-pass ops overwrite resp_data in their final pass before DONE.
      case (state_q)
        P1: begin
          r1_q      <= sh_out;
          resp_data <= is_illegal ? 32'd0 : sh_out;
          resp_err  <= is_illegal;
        end
        P2: begin
`ifdef SHIFT_ARB_ROTATE_EN
          r2_q      <= sh_out;
`endif
          resp_data <= r1_q & ~sh_out;
        end
`ifdef SHIFT_ARB_ROTATE_EN
        P3: resp_data <= r1_q | (r2_q & ~sh_out);
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: round-robin instance plus a FIXED_PRIO=1 instance.
`timescale 1ns/1ps
module tb_shift_unit_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b1;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic [4:0]  req0_amt = '0, req1_amt = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic        req0_ready, req1_ready, resp_valid, resp_id, resp_err, busy;
  logic [31:0] resp_data;

  logic        fp_v0 = 1'b0, fp_v1 = 1'b0;
  logic [31:0] fp_d0 = 32'd1, fp_d1 = 32'd1;
  logic [4:0]  fp_a0 = 5'd1, fp_a1 = 5'd2;
  logic        fp_r0, fp_r1, fp_resp_valid, fp_resp_id, fp_resp_err, fp_busy;
  logic [31:0] fp_resp_data;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  shift_unit_arbiter #(.FIXED_PRIO(1'b0), .INIT_PTR(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  shift_unit_arbiter #(.FIXED_PRIO(1'b1), .INIT_PTR(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .req0_valid(fp_v0), .req0_ready(fp_r0), .req0_data(fp_d0),
    .req0_amt(fp_a0), .req0_op(2'b00),
    .req1_valid(fp_v1), .req1_ready(fp_r1), .req1_data(fp_d1),
    .req1_amt(fp_a1), .req1_op(2'b00),
    .resp_valid(fp_resp_valid), .resp_ready(1'b1), .resp_data(fp_resp_data),
    .resp_id(fp_resp_id), .resp_err(fp_resp_err), .busy(fp_busy)
  );

  // Reference shift semantics, written directly rather than as pass sequences.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
    logic signed [31:0] s;
    logic [63:0]        w;
    s = $signed(d) >>> a;
    w = {d, d} << a;
    case (o)
      2'b00:   return d << a;
      2'b01:   return s;
      2'b10:   return d >> a;
`ifdef SHIFT_ARB_ROTATE_EN
      default: return w[63:32];
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic bit model_err(input logic [1:0] o);
`ifdef SHIFT_ARB_ROTATE_EN
    return 1'b0;
`else
    return o == 2'b11;
`endif
  endfunction

  function automatic int model_lat(input logic [4:0] a, input logic [1:0] o);
    if (a == 5'd0 || !o[1]) return 2;
    if (o == 2'b10) return 3;
`ifdef SHIFT_ARB_ROTATE_EN
    return 4;
`else
    return 2;
`endif
  endfunction

  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got data=%h id=%0d err=%0d, required no response", resp_data, resp_id, resp_err);
      end else begin
        mon_e = sb.pop_front();
        if (resp_data !== mon_e.data || resp_id !== mon_e.id || resp_err !== mon_e.err) begin
          n_fail++;
          $display("FAIL resp_match: got data=%h id=%0d err=%0d, required data=%h id=%0d err=%0d",
                   resp_data, resp_id, resp_err, mon_e.data, mon_e.id, mon_e.err);
        end
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
    if (id) begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_op = o;
    end else begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_op = o;
    end
  endtask

  task automatic wait_ready(input bit id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clock);
  endtask

  task automatic do_reset();
    wait_drain();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic issue(input bit id, input logic [31:0] d, input logic [4:0] a, input logic [1:0] o,
                       input logic [31:0] ed, input bit ee, input int lat);
    bit ok;
    int n;
    @(posedge clock); #1;
    set_req(id, 1'b1, d, a, o);
    wait_ready(id, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL issue_ready: req%0d_ready stayed 0, required 1 within 20 cycles", id);
      set_req(id, 1'b0, d, a, o);
      return;
    end
    sb.push_back('{data: ed, id: id, err: ee});
    @(posedge clock); #1;
    set_req(id, 1'b0, d, a, o);
    @(negedge clock);
    n_assert++;
    if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pass: got busy=%0d r0=%0d r1=%0d resp_valid=%0d, required 1 0 0 0",
               busy, req0_ready, req1_ready, resp_valid);
    end
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    n_assert++;
    if (n != lat) begin
      n_fail++;
      $display("FAIL latency: op=%0d amt=%0d got %0d cycles, required %0d", o, a, n, lat);
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    @(negedge clock);
    n_assert++;
    if ({resp_valid, resp_data, resp_id, resp_err, busy, req0_ready, req1_ready} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0d data=%h id=%0d err=%0d busy=%0d r0=%0d r1=%0d, required all 0",
               resp_valid, resp_data, resp_id, resp_err, busy, req0_ready, req1_ready);
    end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clock);
    n_assert++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%0d resp_valid=%0d, required 0 0", busy, resp_valid);
    end
  endtask

  task automatic test_sll();
    issue(1'b0, 32'h0000_000F, 5'd4, 2'b00, 32'h0000_00F0, 1'b0, 2);
  endtask

  task automatic test_sra_srl();
    issue(1'b1, 32'h8000_0000, 5'd4, 2'b01, 32'hF800_0000, 1'b0, 2);
    issue(1'b1, 32'h8000_0000, 5'd4, 2'b10, 32'h0800_0000, 1'b0, 3);
    issue(1'b1, 32'h8000_0000, 5'd0, 2'b10, 32'h8000_0000, 1'b0, 2);
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    @(posedge clock); #1;
    set_req(1'b0, 1'b1, 32'd1, 5'd1, 2'b00);
    set_req(1'b1, 1'b1, 32'd1, 5'd2, 2'b00);
    @(negedge clock);
    n_assert++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_first_grant: got r0=%0d r1=%0d, required 1 0", req0_ready, req1_ready);
    end
    sb.push_back('{data: 32'h2, id: 1'b0, err: 1'b0});
    @(posedge clock); #1;
    req0_valid = 1'b0;
    wait_ready(1'b1, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_second_grant: req1_ready stayed 0, required 1");
    end else begin
      sb.push_back('{data: 32'h4, id: 1'b1, err: 1'b0});
    end
    @(posedge clock); #1;
    req1_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_fixed_prio();
    int  ng = 0;
    bit  g[2];
    do_reset();
    @(posedge clock); #1;
    fp_v0 = 1'b1;
    fp_v1 = 1'b1;
    for (int i = 0; i < 30 && ng < 2; i++) begin
      @(negedge clock);
      if (fp_resp_valid === 1'b1) begin
        n_assert++;
        if (fp_resp_id !== 1'b0 || fp_resp_data !== 32'h2 || fp_resp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL fp_resp: got id=%0d data=%h err=%0d, required 0 00000002 0", fp_resp_id, fp_resp_data, fp_resp_err);
        end
      end
      if (fp_r0 === 1'b1) begin g[ng] = 1'b0; ng++; end
      else if (fp_r1 === 1'b1) begin g[ng] = 1'b1; ng++; end
    end
    @(posedge clock); #1;
    fp_v0 = 1'b0;
    fp_v1 = 1'b0;
    n_assert++;
    if (ng != 2 || g[0] !== 1'b0 || g[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_grants: got %0d grants ids %0d,%0d, required 2 grants ids 0,0", ng, g[0], g[1]);
    end
    repeat (4) @(negedge clock);
    n_assert++;
    if (fp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_idle: got busy=%0d, required 0", fp_busy);
    end
  endtask

  task automatic test_hold();
    resp_ready = 1'b0;
    issue(1'b0, 32'h0000_1234, 5'd8, 2'b00, 32'h0012_3400, 1'b0, 2);
    @(posedge clock); #1;
    set_req(1'b1, 1'b1, 32'h5, 5'd1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_assert++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h0012_3400 || resp_id !== 1'b0 || resp_err !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got valid=%0d data=%h id=%0d r0=%0d r1=%0d busy=%0d, required 1 00123400 0 0 0 1",
                 i, resp_valid, resp_data, resp_id, req0_ready, req1_ready, busy);
      end
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    req1_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_assert++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_exit: got resp_valid=%0d busy=%0d, required 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_rol();
`ifdef SHIFT_ARB_ROTATE_EN
    issue(1'b0, 32'h8000_0001, 5'd4, 2'b11, 32'h0000_0018, 1'b0, 4);
`else
    issue(1'b0, 32'h8000_0001, 5'd4, 2'b11, 32'h0000_0000, 1'b1, 2);
`endif
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    @(posedge clock); #1;
    set_req(1'b1, 1'b1, 32'h8000_0000, 5'd4, 2'b10);
    wait_ready(1'b1, ok);
    @(posedge clock); #1;
    req1_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_assert++;
    if (!ok || busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_op_setup: got accepted=%0d busy=%0d resp_valid=%0d, required 1 1 0", ok, busy, resp_valid);
    end
    #1 reset = 1'b1;
    #1;
    n_assert++;
    if ({resp_valid, resp_data, resp_id, resp_err, busy, req0_ready, req1_ready} !== 38'd0) begin
      n_fail++;
      $display("FAIL mid_op_reset: got valid=%0d data=%h id=%0d err=%0d busy=%0d r0=%0d r1=%0d, required all 0",
               resp_valid, resp_data, resp_id, resp_err, busy, req0_ready, req1_ready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    issue(1'b0, 32'h0000_0003, 5'd5, 2'b00, 32'h0000_0060, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  amts[10] = '{5'd0, 5'd1, 5'd4, 5'd15, 5'd31, 5'd31, 5'd7, 5'd0, 5'd16, 5'd3};
    logic [31:0] d;
    logic [1:0]  o;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      o = 2'(i % 4);
      issue(1'(i % 2), d, amts[i], o, model(d, amts[i], o), model_err(o), model_lat(amts[i], o));
    end
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_round_robin();
    test_fixed_prio();
    test_hold();
    test_rol();
    test_reset_mid_op();
    test_back_to_back();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding responses, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
